// File: rtl/alu_scheduler.sv
// Arbitrates two requesters onto one shared combinational ALU with round-robin
// priority, sequencing each operation through IDLE -> EXEC -> HOLD.
module alu_scheduler #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [2*N-1:0] req_a,
  input  logic [2*N-1:0] req_b,
  input  logic [7:0]     req_sel,
  output logic [N-1:0]   alu_a,
  output logic [N-1:0]   alu_b,
  output logic [3:0]     alu_sel,
  input  logic [N-1:0]   alu_result,
  input  logic [1:0]     alu_flags,
  output logic [1:0]     rsp_valid,
  input  logic [1:0]     rsp_ready,
  output logic [N-1:0]   rsp_result,
  output logic [1:0]     rsp_flags,
  output logic           rsp_err,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t       state;
  logic         prio;
  logic         owner;
  logic         illegal;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic [3:0]   op_sel;

  logic         win;
  logic [N-1:0] a_in;
  logic [N-1:0] b_in;
  logic [3:0]   sel_in;
  logic         sel_bad;

  // Grant is only offered in IDLE; with both requesting, prio breaks the tie.
  always_comb begin
    req_ready = 2'b00;
    if (state == IDLE) begin
      if (req_valid == 2'b11)
        req_ready = prio ? 2'b10 : 2'b01;
      else
        req_ready = req_valid;
    end
  end

  assign win     = req_ready[1];
  assign a_in    = win ? req_a[2*N-1:N] : req_a[N-1:0];
  assign b_in    = win ? req_b[2*N-1:N] : req_b[N-1:0];
  assign sel_in  = win ? req_sel[7:4] : req_sel[3:0];
  assign sel_bad = (sel_in > 4'd10);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      prio       <= 1'b0;
      owner      <= 1'b0;
      illegal    <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      op_sel     <= 4'd0;
      rsp_result <= '0;
      rsp_flags  <= 2'b00;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_ready) begin
            owner   <= win;
            op_a    <= a_in;
            op_b    <= b_in;
            illegal <= sel_bad;
            op_sel  <= sel_bad ? 4'd0 : sel_in;
            state   <= EXEC;
          end
        end
        // Illegal codes still run the full sequence but report a zeroed result.
        EXEC: begin
          rsp_result <= illegal ? '0 : alu_result;
          rsp_flags  <= illegal ? 2'b00 : alu_flags;
          rsp_err    <= illegal;
          state      <= HOLD;
        end
        HOLD: begin
          if (rsp_ready[owner]) begin
            prio  <= ~owner;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign alu_a     = op_a;
  assign alu_b     = op_b;
  assign alu_sel   = op_sel;
  assign rsp_valid = (state == HOLD) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_scheduler.sv
// Self-checking bench for alu_scheduler: table of single-op vectors plus
// directed sequences for contention, backpressure and mid-operation reset.
module tb_alu_scheduler;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*N-1:0] req_a;
  logic [2*N-1:0] req_b;
  logic [7:0]     req_sel;
  logic [N-1:0]   alu_a;
  logic [N-1:0]   alu_b;
  logic [3:0]     alu_sel;
  logic [N-1:0]   alu_result;
  logic [1:0]     alu_flags;
  logic [1:0]     rsp_valid;
  logic [1:0]     rsp_ready;
  logic [N-1:0]   rsp_result;
  logic [1:0]     rsp_flags;
  logic           rsp_err;
  logic           busy;
  logic [N:0]     aluRaw;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic         req;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   sel;
    logic [N-1:0] res;
    logic [1:0]   flags;
    logic         err;
    logic [3:0]   aluSel;
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  alu_scheduler #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .busy(busy)
  );

  // Shared ALU stand-in: returns {carry, result}; flags are {carry, zero}.
  function automatic logic [N:0] aluModel(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic [3:0] sel);
    case (sel)
      4'd0:    return {1'b0, a} + {1'b0, b};
      4'd1:    return {(a < b), a - b};
      4'd2:    return {1'b0, a & b};
      4'd3:    return {1'b0, a | b};
      4'd4:    return {1'b0, a ^ b};
      4'd5:    return {1'b0, ~a};
      4'd6:    return {1'b0, a << 1};
      4'd7:    return {1'b0, a >> 1};
      4'd8:    return {1'b0, a} + {{N{1'b0}}, 1'b1};
      4'd9:    return {(a == '0), a - {{(N-1){1'b0}}, 1'b1}};
      4'd10:   return {1'b0, b};
      default: return '0;
    endcase
  endfunction

  assign aluRaw     = aluModel(alu_a, alu_b, alu_sel);
  assign alu_result = aluRaw[N-1:0];
  assign alu_flags  = {aluRaw[N], aluRaw[N-1:0] == '0};

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One complete operation from a single requester with immediate response accept.
  task automatic applyStimulus(input vec_t v);
    logic [1:0] oh;
    oh = v.req ? 2'b10 : 2'b01;
    @(negedge clk);
    req_a     = '0;
    req_b     = '0;
    req_sel   = '0;
    if (v.req) begin
      req_a[2*N-1:N] = v.a;
      req_b[2*N-1:N] = v.b;
      req_sel[7:4]   = v.sel;
    end else begin
      req_a[N-1:0] = v.a;
      req_b[N-1:0] = v.b;
      req_sel[3:0] = v.sel;
    end
    req_valid = oh;
    rsp_ready = oh;
    #1;
    checkOutput("vec_req_ready", req_ready, oh);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    checkOutput("vec_exec_busy", busy, 1);
    checkOutput("vec_exec_rsp_valid", rsp_valid, 0);
    checkOutput("vec_alu_a", alu_a, v.a);
    checkOutput("vec_alu_sel", alu_sel, v.aluSel);
    @(negedge clk);
    checkOutput("vec_rsp_valid", rsp_valid, oh);
    checkOutput("vec_rsp_result", rsp_result, v.res);
    checkOutput("vec_rsp_flags", rsp_flags, v.flags);
    checkOutput("vec_rsp_err", rsp_err, v.err);
    checkOutput("vec_hold_busy", busy, 1);
    @(negedge clk);
    checkOutput("vec_idle_busy", busy, 0);
    checkOutput("vec_idle_rsp_valid", rsp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b0, 4'd3,  4'd2,  4'd0,  4'd5,  2'b00, 1'b0, 4'd0};
    vecs[1]  = '{1'b1, 4'd9,  4'd8,  4'd0,  4'd1,  2'b10, 1'b0, 4'd0};
    vecs[2]  = '{1'b0, 4'd2,  4'd5,  4'd1,  4'd13, 2'b10, 1'b0, 4'd1};
    vecs[3]  = '{1'b1, 4'd6,  4'd6,  4'd1,  4'd0,  2'b01, 1'b0, 4'd1};
    vecs[4]  = '{1'b0, 4'd12, 4'd10, 4'd2,  4'd8,  2'b00, 1'b0, 4'd2};
    vecs[5]  = '{1'b1, 4'd12, 4'd3,  4'd4,  4'd15, 2'b00, 1'b0, 4'd4};
    vecs[6]  = '{1'b0, 4'd15, 4'd0,  4'd8,  4'd0,  2'b11, 1'b0, 4'd8};
    vecs[7]  = '{1'b1, 4'd5,  4'd7,  4'd10, 4'd7,  2'b00, 1'b0, 4'd10};
    vecs[8]  = '{1'b0, 4'd3,  4'd2,  4'd14, 4'd0,  2'b00, 1'b1, 4'd0};
    vecs[9]  = '{1'b1, 4'd7,  4'd7,  4'd11, 4'd0,  2'b00, 1'b1, 4'd0};
    vecs[10] = '{1'b0, 4'd1,  4'd4,  4'd6,  4'd2,  2'b00, 1'b0, 4'd6};
    vecs[11] = '{1'b1, 4'd0,  4'd3,  4'd9,  4'd15, 2'b10, 1'b0, 4'd9};

    rst       = 1'b0;
    req_valid = 2'b00;
    req_a     = '0;
    req_b     = '0;
    req_sel   = '0;
    rsp_ready = 2'b00;

    // Reset state, with req_ready still combinational while rst is low.
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_result", rsp_result, 0);
    checkOutput("rst_rsp_flags", rsp_flags, 0);
    checkOutput("rst_rsp_err", rsp_err, 0);
    checkOutput("rst_alu_a", alu_a, 0);
    checkOutput("rst_alu_b", alu_b, 0);
    checkOutput("rst_alu_sel", alu_sel, 0);
    req_valid = 2'b10;
    #1;
    checkOutput("rst_req_ready_single", req_ready, 2'b10);
    req_valid = 2'b11;
    #1;
    checkOutput("rst_req_ready_both", req_ready, 2'b01);
    req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_busy", busy, 0);

    // Request withdrawn before the clock edge must not start an operation.
    req_valid = 2'b01;
    #2;
    req_valid = 2'b00;
    @(negedge clk);
    checkOutput("drop_busy", busy, 0);
    checkOutput("drop_alu_a", alu_a, 0);

    for (int i = 0; i < 12; i++)
      applyStimulus(vecs[i]);

    // Contention: both requesters held valid, grants must alternate from 0.
    pulseReset();
    @(negedge clk);
    req_a     = {4'd4, 4'd1};
    req_b     = {4'd4, 4'd2};
    req_sel   = 8'h00;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] expOh;
      expOh = (i % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      checkOutput("rr_grant", req_ready, expOh);
      @(negedge clk);
      checkOutput("rr_exec_ready", req_ready, 0);
      @(negedge clk);
      checkOutput("rr_rsp_valid", rsp_valid, expOh);
      checkOutput("rr_rsp_result", rsp_result, (i % 2 == 0) ? 3 : 8);
      @(negedge clk);
    end
    req_valid = 2'b00;

    // Backpressure on owner 0, then non-owner ready, then owner ready.
    @(negedge clk);
    req_a     = {4'd0, 4'd6};
    req_b     = {4'd0, 4'd7};
    req_sel   = 8'h00;
    req_valid = 2'b01;
    rsp_ready = 2'b00;
    #1;
    checkOutput("bp_grant", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b10;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_rsp_valid", rsp_valid, 2'b01);
      checkOutput("bp_rsp_result", rsp_result, 13);
      checkOutput("bp_alu_a", alu_a, 6);
      checkOutput("bp_alu_b", alu_b, 7);
      checkOutput("bp_alu_sel", alu_sel, 0);
      checkOutput("bp_req_ready", req_ready, 0);
      checkOutput("bp_busy", busy, 1);
      @(negedge clk);
    end
    rsp_ready = 2'b10;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("nonowner_rsp_valid", rsp_valid, 2'b01);
      checkOutput("nonowner_busy", busy, 1);
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    checkOutput("release_busy", busy, 0);
    checkOutput("release_rsp_valid", rsp_valid, 0);
    checkOutput("release_req_ready", req_ready, 2'b10);
    req_valid = 2'b00;

    // Reset during EXEC discards the operation and restores prio to 0.
    @(negedge clk);
    req_a     = {4'd5, 4'd9};
    req_b     = {4'd1, 4'd3};
    req_sel   = 8'h00;
    req_valid = 2'b10;
    rsp_ready = 2'b11;
    #1;
    checkOutput("mid_grant", req_ready, 2'b10);
    @(negedge clk);
    req_valid = 2'b00;
    checkOutput("mid_exec_busy", busy, 1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_rsp_valid", rsp_valid, 0);
    checkOutput("mid_rst_alu_a", alu_a, 0);
    checkOutput("mid_rst_rsp_result", rsp_result, 0);
    rst = 1'b1;
    req_valid = 2'b11;
    #1;
    checkOutput("mid_rst_prio", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    checkOutput("mid_after_alu_a", alu_a, 9);
    @(negedge clk);
    checkOutput("mid_after_rsp_valid", rsp_valid, 2'b01);
    checkOutput("mid_after_rsp_result", rsp_result, 12);
    @(negedge clk);
    checkOutput("mid_after_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
